// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared types for the CPU front end and the execute-side checkers.
//   - opcode_t        : 4-bit opcode encoding of the 16-bit instruction word
//   - fetch_state_t   : fetch-stage control states
//   - decoded_instr_t : register fields and opcode sliced out of a word
//   - NOP_WORD        : the word the fetch buffer holds out of reset
//   - is_illegal_opcode() : opcodes 4'b1000..4'b1110 have no defined meaning

package cpu_pkg;

    typedef enum logic [3:0] {
        ADD      = 4'd0,
        SUBTRACT = 4'd1,
        AND_OP   = 4'd2,
        OR_OP    = 4'd3,
        XOR_OP   = 4'd4,
        NOT_OP   = 4'd5,
        LOAD     = 4'd6,
        STORE    = 4'd7,
        NOP      = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] reg_hi;
        logic [1:0] reg_ld_a;
        logic [1:0] reg_ld_b;
        logic       illegal;
    } decoded_instr_t;

    localparam logic [15:0] NOP_WORD = 16'h000F;

    // The top bit of the opcode marks the reserved range; 4'hF is NOP and
    // is therefore legal even though its top bit is set.
    function automatic logic is_illegal_opcode(input logic [3:0] opcode);
        return opcode[3] && (opcode != 4'hF);
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// instruction_decoder
//   Pure combinational field extraction of a 16-bit instruction word.
//   Shared between the fetch stage and execute-side checkers.
//   Ports:
//     word    in  16  raw instruction word
//     decoded out     decoded_instr_t (opcode, reg_hi, reg_ld_a, reg_ld_b, illegal)

module instruction_decoder
    import cpu_pkg::*;
(
    input  logic [15:0]    word,
    output decoded_instr_t decoded
);

    // Bits [13:8] carry no register field in any current format.
    logic unused_middle_bits;
    assign unused_middle_bits = ^word[13:8];

    // Slice every field unconditionally; the execute stage picks the ones
    // that match the opcode format.
    always_comb begin
        decoded          = '0;
        decoded.opcode   = word[3:0];
        decoded.reg_hi   = word[15:14];
        decoded.reg_ld_a = word[7:6];
        decoded.reg_ld_b = word[5:4];
        decoded.illegal  = is_illegal_opcode(word[3:0]);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Sequential fetch/decode stage. Drives the program_memory address from
//   the PC register, registers each returned word with its decoded fields
//   into a single-entry output buffer, and hands it on over valid/ready.
//   Fetch halts after the word at LAST_ADDRESS; a redirect restarts it.
//
//   Optional build macro FETCH_SKIP_NOP_EN: when defined, words whose
//   opcode is NOP are never loaded into the buffer (PC still advances).
//
//   Parameters:
//     BITS_FOR_INSTRUCTIONS  PC / address width
//     INSTRUCTION_WIDTH      word width, only 16 is supported
//     LAST_ADDRESS           address of the final instruction
//   Ports:
//     clk, rst                    clock, async active-high reset
//     start                       begin at address 0 (IDLE only)
//     instruction_address  out    address to program_memory (PC register)
//     instruction          in     word for instruction_address
//     redirect_valid/_address in  one-cycle jump request and its target
//     out_valid/out_ready         output handshake
//     out_instruction, out_opcode, out_reg_hi, out_reg_ld_a, out_reg_ld_b,
//     out_pc, out_illegal  out    buffered word, decoded fields, source PC
//     halted               out    fetch has stopped at LAST_ADDRESS

module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int BITS_FOR_INSTRUCTIONS = 5,
    parameter int INSTRUCTION_WIDTH     = 16,
    parameter int LAST_ADDRESS          = 31
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
    input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
    input  logic                             redirect_valid,
    input  logic [BITS_FOR_INSTRUCTIONS-1:0] redirect_address,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [15:0]                      out_instruction,
    output logic [3:0]                       out_opcode,
    output logic [1:0]                       out_reg_hi,
    output logic [1:0]                       out_reg_ld_a,
    output logic [1:0]                       out_reg_ld_b,
    output logic [BITS_FOR_INSTRUCTIONS-1:0] out_pc,
    output logic                             out_illegal,
    output logic                             halted
);

    localparam logic [1:0] IDLE  = FS_IDLE;
    localparam logic [1:0] FETCH = FS_FETCH;
    localparam logic [1:0] HALT  = FS_HALT;

    localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC =
        BITS_FOR_INSTRUCTIONS'(LAST_ADDRESS);
    localparam logic [BITS_FOR_INSTRUCTIONS-1:0] PC_STEP =
        BITS_FOR_INSTRUCTIONS'(1);

    logic [1:0]                       state;
    logic [BITS_FOR_INSTRUCTIONS-1:0] pc;
    decoded_instr_t                   fetched;
    logic                             buffer_free;
    logic                             at_last;
    logic                             capture_word;
    logic                             load_buffer;

    instruction_decoder u_decoder (
        .word    (instruction[15:0]),
        .decoded (fetched)
    );

    assign instruction_address = pc;
    assign halted              = (state == HALT);

    // The buffer can take a new word when it is empty or being drained this
    // very edge; out_ready therefore only reaches registers, never outputs.
    assign buffer_free = !out_valid || out_ready;

    // ">=" also stops a redirect that lands beyond LAST_ADDRESS from
    // running off the end of the program and wrapping.
    assign at_last = (pc >= LAST_PC);

`ifdef FETCH_SKIP_NOP_EN
    assign capture_word = (fetched.opcode != NOP);
`else
    assign capture_word = 1'b1;
`endif

    assign load_buffer = !redirect_valid && (state == FETCH) &&
                         buffer_free && capture_word;

    // Control: state, PC and the valid flag. A redirect wins over every
    // state and throws away whatever the buffer holds, even if the execute
    // stage was accepting it this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            out_valid <= 1'b0;
        end else if (redirect_valid) begin
            state     <= FETCH;
            pc        <= redirect_address;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (start) begin
                        state <= FETCH;
                        pc    <= '0;
                    end
                end
                FETCH: begin
                    if (buffer_free) begin
                        // A skipped NOP still frees the slot, so valid drops.
                        out_valid <= capture_word;
                        if (at_last) begin
                            state <= HALT;
                        end else begin
                            pc <= pc + PC_STEP;
                        end
                    end
                end
                HALT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload of the output buffer; it only changes when a word is loaded,
    // so a stalled execute stage sees perfectly stable fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_instruction <= NOP_WORD;
            out_opcode      <= 4'hF;
            out_reg_hi      <= 2'd0;
            out_reg_ld_a    <= 2'd0;
            out_reg_ld_b    <= 2'd0;
            out_pc          <= '0;
            out_illegal     <= 1'b0;
        end else if (load_buffer) begin
            out_instruction <= instruction[15:0];
            out_opcode      <= fetched.opcode;
            out_reg_hi      <= fetched.reg_hi;
            out_reg_ld_a    <= fetched.reg_ld_a;
            out_reg_ld_b    <= fetched.reg_ld_b;
            out_pc          <= pc;
            out_illegal     <= fetched.illegal;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Scoreboard bench. The program memory lives in the bench. Whenever a
//   start or redirect is issued, the reference model pushes the words the
//   execute stage must receive (target address up to LAST_ADDRESS, in
//   order) into a queue; a negedge monitor pops and compares on every
//   accepted handshake. Directed checks cover reset, latency, stall,
//   halt and redirect behaviour; a randomized phase mixes them.

module tb_instruction_fetch_unit;

    localparam int AW   = 5;
    localparam int LAST = 20;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [15:0]   word;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] instruction_address;
    logic [15:0]   instruction;
    logic          redirect_valid;
    logic [AW-1:0] redirect_address;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_instruction;
    logic [3:0]    out_opcode;
    logic [1:0]    out_reg_hi;
    logic [1:0]    out_reg_ld_a;
    logic [1:0]    out_reg_ld_b;
    logic [AW-1:0] out_pc;
    logic          out_illegal;
    logic          halted;

    logic [15:0]   mem [0:31];
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic          model_idle;
    int            vectors;
    int            miscompares;
    int            cycles;

    instruction_fetch_unit #(
        .BITS_FOR_INSTRUCTIONS (AW),
        .INSTRUCTION_WIDTH     (16),
        .LAST_ADDRESS          (LAST)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .instruction_address (instruction_address),
        .instruction         (instruction),
        .redirect_valid      (redirect_valid),
        .redirect_address    (redirect_address),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_instruction     (out_instruction),
        .out_opcode          (out_opcode),
        .out_reg_hi          (out_reg_hi),
        .out_reg_ld_a        (out_reg_ld_a),
        .out_reg_ld_b        (out_reg_ld_b),
        .out_pc              (out_pc),
        .out_illegal         (out_illegal),
        .halted              (halted)
    );

    assign instruction = mem[instruction_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: after a start or redirect the execute stage must see
    // every address from the target to LAST, in order, each exactly once.
    function automatic void fillExpected(input int from);
        exp_t e;
        exp_q.delete();
        for (int a = from; a <= LAST; a++) begin
`ifdef FETCH_SKIP_NOP_EN
            if (mem[a][3:0] == 4'hF) continue;
`endif
            e.pc   = AW'(a);
            e.word = mem[a];
            exp_q.push_back(e);
        end
    endfunction

    function automatic void initMemory();
        logic [15:0] r;
        for (int a = 0; a < 32; a++) begin
            mem[a] = 16'($urandom);
        end
        for (int a = 0; a <= 9; a++) begin
            r      = 16'($urandom);
            mem[a] = {r[15:4], 4'h0};
        end
        mem[12] = {8'd0, 2'b01, 2'b00, 4'b0110};
        mem[13] = 16'h0009;
        mem[20] = {2'b10, 10'd0, 4'b0111};
    endfunction

    // Inputs are driven 1 time unit after a rising edge; the task returns
    // 1 unit after the next rising edge so its effect can be inspected.
    task automatic applyStimulus(input logic s, input logic rv,
                                 input logic [AW-1:0] ra, input logic rdy);
        start            = s;
        redirect_valid   = rv;
        redirect_address = ra;
        out_ready        = rdy;
        if (rv) begin
            fillExpected(int'(ra));
            model_idle = 1'b0;
        end else if (s && model_idle) begin
            fillExpected(0);
            model_idle = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_halted"}, halted, 0);
        checkOutput({tag, "_out_instruction"}, out_instruction, 16'h000F);
        checkOutput({tag, "_out_opcode"}, out_opcode, 4'hF);
        checkOutput({tag, "_out_reg_hi"}, out_reg_hi, 0);
        checkOutput({tag, "_out_reg_ld_a"}, out_reg_ld_a, 0);
        checkOutput({tag, "_out_reg_ld_b"}, out_reg_ld_b, 0);
        checkOutput({tag, "_out_pc"}, out_pc, 0);
        checkOutput({tag, "_out_illegal"}, out_illegal, 0);
        checkOutput({tag, "_instruction_address"}, instruction_address, 0);
    endtask

    task automatic drainToHalt(input string tag, input logic random_ready);
        cycles = 0;
        while (!(halted && !out_valid) && cycles < 300) begin
            applyStimulus(1'b0, 1'b0, '0,
                          random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            cycles++;
        end
        checkOutput({tag, "_halt_reached"}, halted && !out_valid, 1);
        checkOutput({tag, "_halt_address"}, instruction_address, LAST);
        checkOutput({tag, "_words_outstanding"}, exp_q.size(), 0);
    endtask

    // Monitor: a transfer happens at the next rising edge when valid and
    // ready are both high, unless a redirect or reset discards the word.
    always @(negedge clk) begin
        if (!rst && !redirect_valid && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got pc 0x%0h word 0x%0h, expected none",
                         out_pc, out_instruction);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("out_pc", out_pc, mon_e.pc);
                checkOutput("out_instruction", out_instruction, mon_e.word);
                checkOutput("out_opcode", out_opcode, mon_e.word[3:0]);
                checkOutput("out_reg_hi", out_reg_hi, mon_e.word[15:14]);
                checkOutput("out_reg_ld_a", out_reg_ld_a, mon_e.word[7:6]);
                checkOutput("out_reg_ld_b", out_reg_ld_b, mon_e.word[5:4]);
                checkOutput("out_illegal", out_illegal,
                            (mon_e.word[3:0] >= 4'd8) && (mon_e.word[3:0] <= 4'd14));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b1;
        start            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_address = '0;
        out_ready        = 1'b0;
        model_idle       = 1'b1;
        initMemory();
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Start latency and one-per-cycle throughput.
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("valid_at_start_edge", out_valid, 0);
        checkOutput("address_at_start_edge", instruction_address, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("valid_one_edge_later", out_valid, 1);
        checkOutput("first_out_pc", out_pc, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            checkOutput("stream_out_pc", out_pc, i);
        end

        // Stall three cycles holding word 4.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_out_pc", out_pc, 4);
            checkOutput("stall_out_instruction", out_instruction, mem[4]);
            checkOutput("stall_address", instruction_address, 5);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("resume_out_pc", out_pc, 5);

        drainToHalt("first_run", 1'b1);

        // Start is ignored while halted.
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("start_in_halt_halted", halted, 1);
        checkOutput("start_in_halt_valid", out_valid, 0);
        checkOutput("start_in_halt_address", instruction_address, LAST);

        // Redirect out of HALT.
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b1);
        checkOutput("redirect_halt_valid", out_valid, 0);
        checkOutput("redirect_halt_address", instruction_address, 3);
        checkOutput("redirect_halt_halted", halted, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("redirect_halt_valid_next", out_valid, 1);
        checkOutput("redirect_halt_out_pc", out_pc, 3);

        // Redirect while a word is being accepted: that word is dropped.
        applyStimulus(1'b0, 1'b1, 5'd3, 1'b1);
        checkOutput("redirect_drop_valid", out_valid, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("redirect_drop_out_pc", out_pc, 3);

        // Randomized mix of ready, redirect and stray start pulses.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 19) == 0),
                          AW'($urandom_range(0, LAST)),
                          1'($urandom_range(0, 3) != 0));
        end
        drainToHalt("random_run", 1'b0);

        // Asynchronous reset in the middle of a run.
        applyStimulus(1'b0, 1'b1, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        rst        = 1'b1;
        out_ready  = 1'b0;
        exp_q.delete();
        model_idle = 1'b1;
        #2;
        checkResetState("midrun_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // NOP at address 0.
        mem[0] = 16'h000F;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
`ifdef FETCH_SKIP_NOP_EN
        checkOutput("nop_skipped_valid", out_valid, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("first_out_pc_after_nop", out_pc, 1);
`else
        checkOutput("nop_issued_valid", out_valid, 1);
        checkOutput("nop_out_pc", out_pc, 0);
        checkOutput("nop_out_opcode", out_opcode, 4'hF);
`endif
        drainToHalt("nop_run", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential instruction fetch and decode stage that drives the address port of `program_memory` and consumes its combinational 16-bit instruction word. Holds the program counter and registers each fetched word into a single-entry output buffer. Splits the word into opcode and register fields and hands it to the execute stage over a valid/ready handshake. Supports start, halt-at-last-address and an external redirect (jump) request.

## Interface

Parameters:
- BITS_FOR_INSTRUCTIONS, 5, program-counter / address width
- INSTRUCTION_WIDTH, 16, instruction word width; the block supports only 16
- LAST_ADDRESS, 31, address of the final instruction; fetch halts after issuing it

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin fetching from address 0; ignored unless IDLE
- instruction_address  out  BITS_FOR_INSTRUCTIONS  address to `program_memory`, equal to the PC register
- instruction  in  INSTRUCTION_WIDTH  word returned combinationally for instruction_address
- redirect_valid  in  1  jump request, one-cycle pulse
- redirect_address  in  BITS_FOR_INSTRUCTIONS  jump target
- out_valid  out  1  output buffer holds an instruction
- out_ready  in  1  execute stage accepts
- out_instruction  out  16  raw buffered word
- out_opcode  out  4  bits [3:0]
- out_reg_hi  out  2  bits [15:14] (ALU/STORE register)
- out_reg_ld_a  out  2  bits [7:6] (LOAD field A)
- out_reg_ld_b  out  2  bits [5:4] (LOAD field B)
- out_pc  out  BITS_FOR_INSTRUCTIONS  address the buffered word came from
- out_illegal  out  1  opcode in 4'b1000..4'b1110
- halted  out  1  state is HALT

## Operation

- States: IDLE, FETCH, HALT.
- IDLE:
  - start=1 → FETCH, pc←0.
- FETCH, on each edge where the buffer is free (`!out_valid || out_ready`):
  - Capture instruction, pc and decoded fields into the buffer; out_valid←1.
  - If pc==LAST_ADDRESS: pc holds and state → HALT.
  - Otherwise pc←pc+1.
  - pc is never incremented past LAST_ADDRESS, so there is no wrap.
- FETCH, buffer full and out_ready=0:
  - Stall; pc, buffer and all out_* fields hold stable.
- HALT:
  - No new captures.
  - The buffer still drains: out_valid←0 on handshake.
  - start is ignored.
- Redirect, accepted in any state:
  - out_valid←0; the buffered word is discarded even if out_ready=1 that cycle.
  - pc←redirect_address; state → FETCH.
  - A redirect from HALT resumes fetching.
- Priority: rst > redirect_valid > start > normal advance.
- Decode is pure bit-slicing of the captured word. out_illegal does not block issue.
- rst asserted mid-operation: the in-flight word is lost and the block returns to IDLE.

## Timing

- Reset values:
  - state IDLE, pc 0, out_valid 0, halted 0.
  - out_instruction 16'h000F (NOP), out_opcode 4'hF.
  - out_reg_hi, out_reg_ld_a, out_reg_ld_b, out_pc and out_illegal all 0.
- Start latency: start is sampled at edge N; instruction_address=0 during cycle N..N+1; out_valid rises after edge N+1.
- Throughput: one instruction per cycle while out_ready=1.
- Redirect latency: redirect is sampled at edge N; out_valid is 0 after edge N; the target word is valid after edge N+1.
- The output buffer is a register. instruction_address is a register. No combinational path from out_ready to any output.

## Configuration

- FETCH_SKIP_NOP_EN:
  - Defined: a fetched word with opcode 4'b1111 is not loaded into the buffer. pc still advances (or halts at LAST_ADDRESS), and out_valid follows the normal handshake drain. Execute never sees NOPs.
  - Undefined: NOPs are issued like any other instruction.

## Structure

- Shared package `cpu_pkg`:
  - `opcode_t` enum (ADD 0, SUBTRACT 1, AND_OP 2, OR_OP 3, XOR_OP 4, NOT_OP 5, LOAD 6, STORE 7, NOP 15).
  - `fetch_state_t` enum.
  - `decoded_instr_t` struct: opcode, reg_hi, reg_ld_a, reg_ld_b, illegal.
- Sub-module `instruction_decoder`: combinational 16-bit word → `decoded_instr_t`. Reused later by execute-side checkers.

## Test plan

- Reset then start=1 for one cycle, out_ready=1, memory with ADD at 0..9 → out_pc 0,1,2,… on consecutive cycles; first out_valid two edges after start.
- out_ready held 0 for 3 cycles at out_pc=4 → out_instruction, out_pc and instruction_address stable; resuming gives out_pc 5 next.
- LAST_ADDRESS=20 with STORE `{2'b10,10'd0,4'b0111}` at 20 → out_opcode 7, out_reg_hi 2; halted=1 afterwards; pc stays 20; start ignored.
- LOAD `{8'd0,2'b01,2'b00,4'b0110}` at 12 → out_opcode 6, out_reg_ld_a 1, out_reg_ld_b 0, out_illegal 0. Word 16'h0009 → out_illegal 1.
- redirect_valid with address 3 while out_valid=1 and out_ready=1 → buffered word dropped; next valid out_pc=3. The same redirect while in HALT → fetching resumes at 3.
- With FETCH_SKIP_NOP_EN, NOP at address 0 → first out_pc=1. Without the macro → first out_pc=0, out_opcode 4'hF.
